qconv_requant_relu_pipe: RTL and testbench
==========================================

Name: qconv_requant_relu_pipe

Overview:
Parametrised requantization and activation back-end for the quantized conv layers.
- Input: per-pixel signed accumulator results from a MAC array, each tagged with its output channel.
- Processing: adds the per-channel int32 bias and multiplies by a per-channel fixed-point scale. Then shifts, rounds, adds the zero point and applies the selectable activation (none / ReLU / capped ReLU) with saturation to quint8.
- Versus the existing fixed-scale single-mode conv stage, it generalises to per-channel scale, runtime activation mode, valid/ready backpressure and a frame-completion pulse.

Parameters:
- OUT_CHANNELS, 128, number of output channels; sizes the bias and scale tables.
- ACC_W, 24, signed accumulator input width.
- SCALE_W, 32, unsigned scale width.
- SHIFT, 26, fraction bits of scale (real scale = scale / 2^SHIFT).
- FRAME_W, 20, width of the frame-length and output counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- bias_we  in  1  bias table write enable.
- bias_addr  in  clog2(OUT_CHANNELS)  bias write address.
- bias_din  in  32  signed bias.
- scale_we  in  1  scale table write enable.
- scale_addr  in  clog2(OUT_CHANNELS)  scale write address.
- scale_din  in  SCALE_W  unsigned scale.
- zero_point  in  8  output zero point; quasi-static.
- act_mode  in  2  activation mode: 00 none, 01 ReLU, 10 capped ReLU, 11 treated as 01.
- cap_q  in  8  upper clamp used in mode 10.
- frame_len  in  FRAME_W  outputs per frame; 0 disables done.
- in_valid  in  1  accumulator valid.
- in_ready  out  1  pipeline can accept.
- in_acc  in  ACC_W  signed accumulator.
- in_ch  in  clog2(OUT_CHANNELS)  channel of in_acc.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  8  quint8 result.
- done  out  1  one-cycle pulse on the last output of a frame.

Behaviour:
- Reset: out_valid=0, out_data=0, done=0, all stage valids cleared, output counter=0. Tables are NOT cleared; contents are undefined until written.
- Table writes:
  - Take effect at the clock edge.
  - An input accepted in the same cycle as a write to its channel uses the old value.
  - bias and scale may both be written in the same cycle.
- Handshake:
  - Transfer on in_valid&in_ready, and on out_valid&out_ready.
  - stall = out_valid & ~out_ready; in_ready = ~stall. The pipeline holds all stages while stall is asserted.
  - out_data is stable while out_valid is high and out_ready is low.
- Latency: 3 cycles from input acceptance to out_valid when there is no stall. Throughput is 1 result per cycle.
- S1 (bias add): sum = sext(in_acc) + bias[in_ch], held at 33 bits signed. The channel's scale is registered alongside.
- S2 (scale): prod = sum * {0,scale}, signed, 33+SCALE_W+1 bits.
- S3 (requant and activation):
  - q = prod >>> SHIFT (arithmetic shift), rounded or truncated per the optional feature.
  - y = q + zero_point.
  - Lower bound: 0 in mode 00; zero_point in modes 01/10/11.
  - Upper bound: 255 in modes 00/01/11; min(cap_q,255) in mode 10.
  - If cap_q < lower bound in mode 10, the result is the lower bound.
  - out_data = clamp(y, lower bound, upper bound). No intermediate wrap is permitted.
- Frame counter:
  - Increments on each output transfer.
  - When the count reaches frame_len-1 and a transfer occurs: done=1 that same cycle (combined with the transfer) and the counter returns to 0.
  - frame_len=0 means done is never asserted and the counter wraps at 2^FRAME_W.
- Reset mid-operation: all in-flight results are discarded with no output, and the counter clears.

Optional Feature:
- Macro: QREQUANT_ROUND_EN.
- Defined: before the shift, prod += 2^(SHIFT-1) (round half toward +inf).
- Undefined: plain arithmetic shift (floor).
- Latency and interface are identical in both builds.

Test Plan:
- Setup: bias[3]=0, scale[3]=11226920, zp=0, mode=01. Input in_acc=100, ch=3 -> out_data=16 (truncate build) / 17 (QREQUANT_ROUND_EN), exactly 3 cycles after acceptance.
- Same channel, in_acc=-100, modes 01 and 00 -> 0. Same channel, in_acc=2000 -> 255 (saturated). Mode 10 with cap_q=6, in_acc=100 -> 6.
- Bias: bias[5]=-50, scale[5]=1<<26, zp=10, mode=01. in_acc=70 -> 30; in_acc=20 -> 10 (clamped at zero point).
- Backpressure: stream 8 inputs with out_ready low for cycles 4-9 -> in_ready low while stalled, no loss or duplication, 8 outputs in order, out_data stable during the stall.
- Frame: frame_len=4, 10 back-to-back inputs -> done pulses with output #4 and output #8 only. With frame_len=0 -> no done.
- Hazard and reset: write scale[3]=2<<26 in the same cycle an input on ch=3 is accepted -> that input uses the old scale and the next one uses the new scale. Assert rst with 3 results in flight -> no out_valid afterwards, and the counter restarts so done fires on the first full frame after reset.

Source files
------------

// File: rtl/qconv_requant_relu_pipe.sv
// rtl/qconv_requant_relu_pipe.sv - per-channel requantization and activation pipeline
//
// Purpose:
//   Three-stage back-end for quantized conv layers. Each pixel accumulator,
//   tagged with its output channel, gets the channel bias added (S1), is
//   multiplied by the channel fixed-point scale (S2), then shifted, offset by
//   the zero point, clamped per the activation mode and saturated to quint8
//   (S3). A whole-pipeline stall implements valid/ready backpressure, and a
//   frame counter raises done together with the last output transfer of a frame.
//
// Optional build macro:
//   QREQUANT_ROUND_EN - round half toward +inf before the shift (default: floor).
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   bias_we/bias_addr/bias_din       per-channel signed int32 bias write
//   scale_we/scale_addr/scale_din    per-channel unsigned scale write
//   zero_point, act_mode, cap_q      output zero point, activation mode, capped-ReLU limit
//   frame_len                        outputs per frame (0 disables done)
//   in_valid/in_ready/in_acc/in_ch   accumulator input stream
//   out_valid/out_ready/out_data     quint8 result stream
//   done                             pulse on the last output transfer of a frame
module qconv_requant_relu_pipe #(
    parameter int OUT_CHANNELS = 128,
    parameter int ACC_W        = 24,
    parameter int SCALE_W      = 32,
    parameter int SHIFT        = 26,
    parameter int FRAME_W      = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bias_we,
    input  logic [$clog2(OUT_CHANNELS)-1:0] bias_addr,
    input  logic [31:0]                     bias_din,
    input  logic                            scale_we,
    input  logic [$clog2(OUT_CHANNELS)-1:0] scale_addr,
    input  logic [SCALE_W-1:0]              scale_din,
    input  logic [7:0]                      zero_point,
    input  logic [1:0]                      act_mode,
    input  logic [7:0]                      cap_q,
    input  logic [FRAME_W-1:0]              frame_len,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ACC_W-1:0]                in_acc,
    input  logic [$clog2(OUT_CHANNELS)-1:0] in_ch,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [7:0]                      out_data,
    output logic                            done
);
    localparam int SUM_W  = 33;
    localparam int PROD_W = SUM_W + SCALE_W + 1;
    localparam int Y_W    = PROD_W + 1;

    // Coefficient tables; intentionally not reset.
    logic [31:0]        r_bias  [OUT_CHANNELS];
    logic [SCALE_W-1:0] r_scale [OUT_CHANNELS];

    logic                     r_s1_valid;
    logic signed [SUM_W-1:0]  r_s1_sum;
    logic [SCALE_W-1:0]       r_s1_scale;
    logic                     r_s2_valid;
    logic signed [PROD_W-1:0] r_s2_prod;
    logic                     r_out_valid;
    logic [7:0]               r_out_data;
    logic [FRAME_W-1:0]       r_cnt;

    logic                     w_stall;
    logic                     w_accept;
    logic                     w_xfer;
    logic                     w_last;
    logic signed [SUM_W-1:0]  w_acc_x;
    logic signed [SUM_W-1:0]  w_bias_x;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [PROD_W-1:0] w_sum_x;
    logic signed [PROD_W-1:0] w_scale_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_prod_rnd;
    logic signed [PROD_W-1:0] w_q;
    logic signed [Y_W-1:0]    w_y;
    logic signed [Y_W-1:0]    w_lo_x;
    logic signed [Y_W-1:0]    w_hi_x;
    logic [7:0]               w_lo;
    logic [7:0]               w_hi;
    logic [7:0]               w_res;

    assign w_stall  = r_out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & in_ready;
    assign w_xfer   = r_out_valid & out_ready;
    assign w_last   = (frame_len != '0) && (r_cnt == frame_len - 1'b1);

    // Reads happen before the edge that commits a same-cycle write, so an
    // input accepted alongside a write to its channel sees the old entry.
    always_ff @(posedge clk) begin
        if (bias_we)
            r_bias[bias_addr] <= bias_din;
        if (scale_we)
            r_scale[scale_addr] <= scale_din;
    end

    // S1: bias add at full 33-bit precision
    assign w_acc_x  = {{(SUM_W-ACC_W){in_acc[ACC_W-1]}}, in_acc};
    assign w_bias_x = {r_bias[in_ch][31], r_bias[in_ch]};
    assign w_sum    = w_acc_x + w_bias_x;

    // S2: signed sum times zero-extended unsigned scale
    assign w_sum_x   = {{(PROD_W-SUM_W){r_s1_sum[SUM_W-1]}}, r_s1_sum};
    assign w_scale_x = {{(PROD_W-SCALE_W){1'b0}}, r_s1_scale};
    assign w_prod    = w_sum_x * w_scale_x;

    // S3: requantize; product is wide enough that the rounding add cannot wrap
`ifdef QREQUANT_ROUND_EN
    assign w_prod_rnd = r_s2_prod + (PROD_W'(1) << (SHIFT - 1));
`else
    assign w_prod_rnd = r_s2_prod;
`endif
    assign w_q    = w_prod_rnd >>> SHIFT;
    assign w_y    = {w_q[PROD_W-1], w_q} + {{(Y_W-8){1'b0}}, zero_point};
    assign w_lo   = (act_mode == 2'b00) ? 8'd0 : zero_point;
    assign w_hi   = (act_mode == 2'b10) ? cap_q : 8'hFF;
    assign w_lo_x = {{(Y_W-8){1'b0}}, w_lo};
    assign w_hi_x = {{(Y_W-8){1'b0}}, w_hi};

    // A cap below the lower bound collapses the range onto the lower bound.
    always_comb begin
        w_res = w_y[7:0];
        if (w_y < w_lo_x)
            w_res = w_lo;
        else if (w_y > w_hi_x)
            w_res = (w_hi < w_lo) ? w_lo : w_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_cnt       <= '0;
        end else begin
            if (!w_stall) begin
                r_s1_valid  <= w_accept;
                r_s2_valid  <= r_s1_valid;
                r_out_valid <= r_s2_valid;
                if (r_s2_valid)
                    r_out_data <= w_res;
            end
            if (w_xfer)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Datapath registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        if (!w_stall) begin
            if (w_accept) begin
                r_s1_sum   <= w_sum;
                r_s1_scale <= r_scale[in_ch];
            end
            if (r_s1_valid)
                r_s2_prod <= w_prod;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = w_xfer & w_last;
endmodule

// File: tb/tb_qconv_requant_relu_pipe.sv
// tb/tb_qconv_requant_relu_pipe.sv - scoreboard bench for qconv_requant_relu_pipe
module tb_qconv_requant_relu_pipe;
    localparam int NCH = 128;
`ifdef QREQUANT_ROUND_EN
    localparam int EXP100 = 17;
`else
    localparam int EXP100 = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bias_we;
    logic [6:0]  bias_addr;
    logic [31:0] bias_din;
    logic        scale_we;
    logic [6:0]  scale_addr;
    logic [31:0] scale_din;
    logic [7:0]  zero_point;
    logic [1:0]  act_mode;
    logic [7:0]  cap_q;
    logic [19:0] frame_len;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_acc;
    logic [6:0]  in_ch;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        done;

    always #5 clk = ~clk;

    qconv_requant_relu_pipe dut (
        .clk(clk), .rst(rst),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_din(bias_din),
        .scale_we(scale_we), .scale_addr(scale_addr), .scale_din(scale_din),
        .zero_point(zero_point), .act_mode(act_mode), .cap_q(cap_q),
        .frame_len(frame_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done)
    );

    int     n_vec = 0;
    int     n_miss = 0;
    int     exp_q[$];
    int     done_at[$];
    longint m_bias[NCH];
    longint m_scale[NCH];
    int     m_cnt = 0;
    int     n_out = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int acc, input int ch);
        longint s, p, y, lo, hi;
        s = longint'(acc) + m_bias[ch];
        p = s * m_scale[ch];
`ifdef QREQUANT_ROUND_EN
        p = p + (longint'(1) << 25);
`endif
        y  = (p >>> 26) + longint'(zero_point);
        lo = (act_mode == 2'b00) ? 64'sd0 : longint'(zero_point);
        hi = (act_mode == 2'b10) ? longint'(cap_q) : 64'sd255;
        if (y > hi) y = hi;
        if (y < lo) y = lo;
        return int'(y);
    endfunction

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", out_valid, 0);
                end else begin
                    int  e;
                    logic ed;
                    e  = exp_q.pop_front();
                    ed = (frame_len != 0) && (m_cnt == int'(frame_len) - 1);
                    chk("out_data", out_data, e);
                    chk("done", done, ed);
                    m_cnt = ed ? 0 : m_cnt + 1;
                    n_out++;
                    if (done) done_at.push_back(n_out);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic send(input int acc, input int ch, input int exp);
        logic rdy;
        in_valid = 1'b1;
        in_acc   = acc[23:0];
        in_ch    = ch[6:0];
        for (int t = 0; ; t++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back(exp);
                break;
            end
            if (t > 200) begin
                chk("in_ready_timeout", in_ready, 1);
                break;
            end
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_bias(input int ch, input int val);
        bias_we = 1'b1; bias_addr = ch[6:0]; bias_din = val;
        idle(1);
        bias_we = 1'b0;
        m_bias[ch] = longint'(val);
    endtask

    task automatic wr_scale(input int ch, input longint val);
        scale_we = 1'b1; scale_addr = ch[6:0]; scale_din = val[31:0];
        idle(1);
        scale_we = 1'b0;
        m_scale[ch] = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bias_we = 0; bias_addr = 0; bias_din = 0;
        scale_we = 0; scale_addr = 0; scale_din = 0;
        zero_point = 0; act_mode = 2'b01; cap_q = 0; frame_len = 0;
        in_valid = 0; in_acc = 0; in_ch = 0; out_ready = 1'b1;
        idle(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        // Basic scaling with ReLU, plus exact latency
        wr_bias(3, 0);
        wr_scale(3, 11226920);
        send(100, 3, EXP100);
        chk("lat_c1", out_valid, 0);
        idle(1);
        chk("lat_c2", out_valid, 0);
        idle(1);
        chk("lat_c3", out_valid, 1);
        chk("lat_data", out_data, EXP100);
        idle(3);
        send(-100, 3, 0);      idle(4);
        act_mode = 2'b00;
        send(-100, 3, 0);      idle(4);
        act_mode = 2'b01;
        send(2000, 3, 255);    idle(4);
        act_mode = 2'b10; cap_q = 8'd6;
        send(100, 3, 6);       idle(4);

        // Bias and zero point
        wr_bias(5, -50);
        wr_scale(5, longint'(1) << 26);
        zero_point = 8'd10; act_mode = 2'b01;
        send(70, 5, 30);
        send(20, 5, 10);       idle(4);
        act_mode = 2'b00;
        send(20, 5, 0);        idle(4);
        act_mode = 2'b11;
        send(20, 5, 10);       idle(4);
        act_mode = 2'b10; cap_q = 8'd6;
        send(70, 5, 10);       idle(4);

        // Backpressure: out_ready low for six cycles mid-stream
        act_mode = 2'b01; zero_point = 8'd3;
        begin
            int n0;
            n0 = n_out;
            fork
                for (int i = 0; i < 8; i++) begin
                    int a, c;
                    a = i * 37 - 60;
                    c = (i % 2 == 1) ? 3 : 5;
                    send(a, c, model(a, c));
                end
                begin
                    repeat (3) @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    repeat (6) begin
                        @(negedge clk);
                        chk("bp_in_ready", in_ready, 0);
                        chk("bp_out_valid", out_valid, 1);
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1'b1;
                end
            join
            idle(8);
            chk("bp_count", n_out - n0, 8);
            chk("bp_queue_empty", exp_q.size(), 0);
        end

        // Frames of four
        rst = 1'b1; idle(2); rst = 1'b0;
        frame_len = 20'd4; n_out = 0; done_at.delete();
        for (int i = 0; i < 10; i++) send(i * 50, 5, model(i * 50, 5));
        idle(6);
        chk("frame_done_count", done_at.size(), 2);
        if (done_at.size() >= 2) begin
            chk("frame_done_first", done_at[0], 4);
            chk("frame_done_second", done_at[1], 8);
        end

        // frame_len = 0 disables done
        frame_len = 20'd0; n_out = 0; done_at.delete();
        for (int i = 0; i < 10; i++) send(i * 20, 3, model(i * 20, 3));
        idle(6);
        chk("frame0_done_count", done_at.size(), 0);

        // Same-cycle scale write and input on that channel
        zero_point = 8'd0; act_mode = 2'b01;
        scale_we = 1'b1; scale_addr = 7'd3; scale_din = 32'd2 << 26;
        send(100, 3, EXP100);
        scale_we = 1'b0;
        m_scale[3] = longint'(2) << 26;
        send(100, 3, 200);
        idle(6);
        chk("hazard_queue_empty", exp_q.size(), 0);

        // Reset with three results in flight
        frame_len = 20'd4;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(10 + i, 3, model(10 + i, 3));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_flush_valid", out_valid, 0);
        end
        idle(1);
        n_out = 0; done_at.delete();
        for (int i = 0; i < 4; i++) send(i * 30, 3, model(i * 30, 3));
        idle(6);
        chk("post_rst_done_count", done_at.size(), 1);
        if (done_at.size() >= 1)
            chk("post_rst_done_idx", done_at[0], 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
